// File: rtl/cache_types.sv
// Shared cache-side types and sizing constants for the line/burst memory interface.
package cache_types;

    localparam int unsigned S_LINE    = 256;
    localparam int unsigned S_BURST   = 64;
    localparam int unsigned NUM_BEATS = S_LINE / S_BURST;
    localparam int unsigned COUNT_W   = $clog2(NUM_BEATS);
    localparam int unsigned S_OFFSET  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adaptor_state_t;

    // Memory only ever sees whole-line addresses.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
    endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts single-cycle cache line requests into num_beats-long memory bursts,
// assembling fills beat by beat and streaming writebacks from a latched line.
module cacheline_adaptor
    import cache_types::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [S_LINE-1:0]   line_i,
    output logic [S_LINE-1:0]   line_o,
    input  logic [31:0]         address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [S_BURST-1:0]  burst_i,
    output logic [S_BURST-1:0]  burst_o,
    output logic [31:0]         address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    adaptor_state_t                          state_r, state_s;
    logic [COUNT_W-1:0]                      count_r, count_s;
    logic [NUM_BEATS-1:0][S_BURST-1:0]       fill_r;
    logic [NUM_BEATS-1:0][S_BURST-1:0]       wline_r, wline_s;
    logic [31:0]                             address_r, address_s;
    logic                                    read_r, read_s;
    logic                                    write_r, write_s;
    logic                                    resp_r, resp_s;
    logic                                    fill_en_s;
    logic                                    last_beat_s;

    assign last_beat_s = (count_r == COUNT_W'(NUM_BEATS - 1));

    // Next-state, next-output and datapath-enable decode.
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        wline_s   = wline_r;
        address_s = address_r;
        read_s    = 1'b0;
        write_s   = 1'b0;
        resp_s    = 1'b0;
        fill_en_s = 1'b0;

        case (state_r)
            IDLE: begin
                // Write wins when both requests are (illegally) raised together.
                if (write_i) begin
                    state_s   = WRITE;
                    address_s = line_align(address_i);
                    wline_s   = line_i;
                    write_s   = 1'b1;
                end else if (read_i) begin
                    state_s   = READ;
                    address_s = line_align(address_i);
                    read_s    = 1'b1;
                end else begin
                    state_s   = IDLE;
                end
            end

            READ: begin
                if (resp_i) begin
                    fill_en_s = 1'b1;
                    if (last_beat_s) begin
                        count_s = '0;
                        state_s = DONE;
                        resp_s  = 1'b1;
                    end else begin
                        count_s = count_r + COUNT_W'(1);
                        read_s  = 1'b1;
                    end
                end else begin
                    read_s = 1'b1;
                end
            end

            WRITE: begin
                if (resp_i) begin
                    if (last_beat_s) begin
                        count_s = '0;
                        state_s = DONE;
                        resp_s  = 1'b1;
                    end else begin
                        count_s = count_r + COUNT_W'(1);
                        write_s = 1'b1;
                    end
                end else begin
                    write_s = 1'b1;
                end
            end

            DONE: begin
                state_s = IDLE;
            end

            default: begin
                state_s = IDLE;
                count_s = '0;
            end
        endcase
    end

    // State, counter, latched request and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            count_r   <= '0;
            fill_r    <= '0;
            wline_r   <= '0;
            address_r <= 32'h0000_0000;
            read_r    <= 1'b0;
            write_r   <= 1'b0;
            resp_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            count_r   <= count_s;
            wline_r   <= wline_s;
            address_r <= address_s;
            read_r    <= read_s;
            write_r   <= write_s;
            resp_r    <= resp_s;
            if (fill_en_s) begin
                fill_r[count_r] <= burst_i;
            end
        end
    end

    assign line_o    = fill_r;
    assign burst_o   = wline_r[count_r];
    assign address_o = address_r;
    assign read_o    = read_r;
    assign write_o   = write_r;
    assign resp_o    = resp_r;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench: drives cache requests and a memory responder with
// random beat gaps, and checks against an arithmetic model of line transfers.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int n_tests = 0;
    int n_fail  = 0;
    logic [255:0] exp_line_o;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_align(input logic [31:0] a);
        return a - (a % 32);
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    // Beat pattern with exactly four 1s, the last bit being the fourth 1.
    task automatic make_pattern(output logic [31:0] pat, output int plen);
        int ones;
        ones = 0; plen = 0; pat = 32'h0;
        while (ones < 4) begin
            if (plen < 20 && $urandom_range(0, 99) < 35) begin
                pat[plen] = 1'b0;
            end else begin
                pat[plen] = 1'b1;
                ones++;
            end
            plen++;
        end
    endtask

    // Runs one fill; memory supplies beat k of mem_line on the k-th strobe.
    task automatic do_read(input logic [31:0] addr, input logic [255:0] mem_line,
                           input logic [31:0] pat, input int plen,
                           output logic [31:0] addr_seen, output logic [255:0] line_seen,
                           output int rd_cyc, output int wr_cyc, output int resp_cnt,
                           output bit resp_ok);
        int k;
        k = 0; rd_cyc = 0; wr_cyc = 0; resp_cnt = 0;
        read_i = 1'b1; write_i = 1'b0; address_i = addr; resp_i = 1'b0;
        @(negedge clk);
        addr_seen = address_o;
        for (int i = 0; i < plen; i++) begin
            if (read_o) rd_cyc++;
            if (write_o) wr_cyc++;
            if (resp_o) resp_cnt++;
            resp_i = pat[i];
            if (pat[i]) begin
                burst_i = mem_line[64*k +: 64];
                k++;
            end else begin
                burst_i = {$urandom, $urandom};
            end
            @(negedge clk);
        end
        resp_ok   = resp_o && !read_o && !write_o;
        line_seen = line_o;
        if (resp_o) resp_cnt++;
        read_i = 1'b0; resp_i = 1'b0; burst_i = {$urandom, $urandom};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (read_o) rd_cyc++;
            if (write_o) wr_cyc++;
            if (resp_o) resp_cnt++;
        end
    endtask

    // Runs one writeback; captures burst_o on every strobed beat.
    task automatic do_write(input logic [31:0] addr, input logic [255:0] wl, input bit also_read,
                            input logic [31:0] pat, input int plen,
                            output logic [31:0] addr_seen, output logic [255:0] beats_seen,
                            output int rd_cyc, output int wr_cyc, output int resp_cnt,
                            output bit resp_ok, output logic [255:0] line_o_seen);
        int k;
        k = 0; rd_cyc = 0; wr_cyc = 0; resp_cnt = 0; beats_seen = '0;
        write_i = 1'b1; read_i = also_read; address_i = addr; line_i = wl; resp_i = 1'b0;
        @(negedge clk);
        addr_seen = address_o;
        for (int i = 0; i < plen; i++) begin
            if (read_o) rd_cyc++;
            if (write_o) wr_cyc++;
            if (resp_o) resp_cnt++;
            if (pat[i] && k < 4) begin
                beats_seen[64*k +: 64] = burst_o;
                k++;
            end
            resp_i = pat[i];
            burst_i = {$urandom, $urandom};
            @(negedge clk);
        end
        resp_ok     = resp_o && !read_o && !write_o;
        line_o_seen = line_o;
        if (resp_o) resp_cnt++;
        write_i = 1'b0; read_i = 1'b0; resp_i = 1'b0; line_i = rand_line();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (read_o) rd_cyc++;
            if (write_o) wr_cyc++;
            if (resp_o) resp_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_tests++; if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got rd=%b wr=%b resp=%b, want 0 0 0", read_o, write_o, resp_o);
        end
        n_tests++; if (address_o !== 32'h0 || burst_o !== 64'h0 || line_o !== 256'h0) begin
            n_fail++; $display("FAIL reset_data: got addr=%h burst=%h line=%h, want zeros", address_o, burst_o, line_o);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        exp_line_o = '0;
        @(negedge clk);
        n_tests++; if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: got rd=%b wr=%b resp=%b, want 0 0 0", read_o, write_o, resp_o);
        end
    endtask

    task automatic test_idle_resp();
        int bad;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            resp_i = 1'b1; burst_i = {$urandom, $urandom};
            @(negedge clk);
            if (read_o || write_o || resp_o) bad++;
        end
        resp_i = 1'b0;
        n_tests++; if (bad !== 0 || line_o !== exp_line_o) begin
            n_fail++; $display("FAIL idle_resp: got %0d active cycles line=%h, want 0 line=%h", bad, line_o, exp_line_o);
        end
    endtask

    task automatic test_read_basic();
        logic [255:0] ml, ls; logic [31:0] as; int rc, wc, pc; bit ok;
        ml = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        do_read(32'h0000_1047, ml, 32'hF, 4, as, ls, rc, wc, pc, ok);
        exp_line_o = ml;
        n_tests++; if (as !== 32'h0000_1040) begin
            n_fail++; $display("FAIL read_addr: got %h, want %h", as, 32'h0000_1040);
        end
        n_tests++; if (rc !== 4 || wc !== 0) begin
            n_fail++; $display("FAIL read_cmd: got read_o %0d cyc write_o %0d cyc, want 4 0", rc, wc);
        end
        n_tests++; if (pc !== 1 || !ok) begin
            n_fail++; $display("FAIL read_resp: got %0d pulses timing_ok=%b, want 1 1", pc, ok);
        end
        n_tests++; if (ls !== ml) begin
            n_fail++; $display("FAIL read_line: got %h, want %h", ls, ml);
        end
    endtask

    task automatic test_write_basic();
        logic [255:0] wl, bs, lo; logic [31:0] as; int rc, wc, pc; bit ok;
        wl = {64'hD3D3_0303_D3D3_0303, 64'hD2D2_0202_D2D2_0202,
              64'hD1D1_0101_D1D1_0101, 64'hD0D0_0000_D0D0_0000};
        do_write(32'h0000_2000, wl, 1'b0, 32'hF, 4, as, bs, rc, wc, pc, ok, lo);
        n_tests++; if (as !== 32'h0000_2000) begin
            n_fail++; $display("FAIL write_addr: got %h, want %h", as, 32'h0000_2000);
        end
        n_tests++; if (wc !== 4 || rc !== 0) begin
            n_fail++; $display("FAIL write_cmd: got write_o %0d cyc read_o %0d cyc, want 4 0", wc, rc);
        end
        n_tests++; if (bs !== wl) begin
            n_fail++; $display("FAIL write_beats: got %h, want %h", bs, wl);
        end
        n_tests++; if (pc !== 1 || !ok) begin
            n_fail++; $display("FAIL write_resp: got %0d pulses timing_ok=%b, want 1 1", pc, ok);
        end
    endtask

    task automatic test_read_gaps();
        logic [255:0] ml, ls; logic [31:0] as; int rc, wc, pc; bit ok;
        ml = rand_line();
        do_read(32'h0000_30FF, ml, 32'b1011001, 7, as, ls, rc, wc, pc, ok);
        exp_line_o = ml;
        n_tests++; if (ls !== ml) begin
            n_fail++; $display("FAIL gap_line: got %h, want %h", ls, ml);
        end
        n_tests++; if (pc !== 1 || !ok || rc !== 7) begin
            n_fail++; $display("FAIL gap_resp: got %0d pulses ok=%b read_cyc=%0d, want 1 1 7", pc, ok, rc);
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] wl, ml, ls; logic [31:0] as; int rc, wc, pc; bit ok;
        wl = rand_line();
        write_i = 1'b1; address_i = 32'h0000_4444; line_i = wl;
        @(negedge clk);
        write_i = 1'b1; resp_i = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        exp_line_o = '0;
        n_tests++; if (write_o !== 1'b0 || read_o !== 1'b0 || resp_o !== 1'b0 || address_o !== 32'h0) begin
            n_fail++; $display("FAIL midrst_ctrl: got wr=%b rd=%b resp=%b addr=%h, want zeros", write_o, read_o, resp_o, address_o);
        end
        n_tests++; if (burst_o !== 64'h0 || line_o !== 256'h0) begin
            n_fail++; $display("FAIL midrst_data: got burst=%h line=%h, want zeros", burst_o, line_o);
        end
        write_i = 1'b0; resp_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ml = rand_line();
        do_read(32'h0000_5010, ml, 32'hF, 4, as, ls, rc, wc, pc, ok);
        exp_line_o = ml;
        n_tests++; if (ls !== ml || pc !== 1 || !ok) begin
            n_fail++; $display("FAIL midrst_read: got line=%h pulses=%0d ok=%b, want line=%h 1 1", ls, pc, ok, ml);
        end
    endtask

    task automatic test_both();
        logic [255:0] wl, bs, lo; logic [31:0] as; int rc, wc, pc; bit ok;
        wl = rand_line();
        do_write(32'h0000_6021, wl, 1'b1, 32'hF, 4, as, bs, rc, wc, pc, ok, lo);
        n_tests++; if (rc !== 0 || wc !== 4 || pc !== 1) begin
            n_fail++; $display("FAIL both_req: got read_cyc=%0d write_cyc=%0d pulses=%0d, want 0 4 1", rc, wc, pc);
        end
        n_tests++; if (bs !== wl || as !== 32'h0000_6020) begin
            n_fail++; $display("FAIL both_data: got beats=%h addr=%h, want %h %h", bs, as, wl, 32'h0000_6020);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] ml, ls, wl, bs, lo; logic [31:0] as; int rc, wc, pc; bit ok;
        ml = rand_line();
        do_read(32'h0000_7000, ml, 32'hF, 4, as, ls, rc, wc, pc, ok);
        exp_line_o = ml;
        n_tests++; if (ls !== ml || pc !== 1 || rc !== 4) begin
            n_fail++; $display("FAIL b2b_read: got line=%h pulses=%0d rd=%0d, want line=%h 1 4", ls, pc, rc, ml);
        end
        wl = rand_line();
        do_write(32'h0000_8000, wl, 1'b0, 32'hF, 4, as, bs, rc, wc, pc, ok, lo);
        n_tests++; if (lo !== exp_line_o || line_o !== exp_line_o) begin
            n_fail++; $display("FAIL b2b_retain: got %h, want %h", lo, exp_line_o);
        end
        n_tests++; if (bs !== wl || pc !== 1 || rc !== 0) begin
            n_fail++; $display("FAIL b2b_write: got beats=%h pulses=%0d rd=%0d, want %h 1 0", bs, pc, rc, wl);
        end
    endtask

    task automatic test_random();
        logic [255:0] ml, ls, bs, lo; logic [31:0] as, a, pat; int rc, wc, pc, plen; bit ok;
        for (int it = 0; it < 24; it++) begin
            a = $urandom;
            ml = rand_line();
            make_pattern(pat, plen);
            if ($urandom_range(0, 1) == 0) begin
                do_read(a, ml, pat, plen, as, ls, rc, wc, pc, ok);
                exp_line_o = ml;
                n_tests++; if (ls !== ml || as !== model_align(a) || pc !== 1 || !ok || rc !== plen || wc !== 0) begin
                    n_fail++; $display("FAIL rand_read%0d: got line=%h addr=%h resp=%0d ok=%b rd=%0d wr=%0d, want line=%h addr=%h 1 1 %0d 0",
                                       it, ls, as, pc, ok, rc, wc, ml, model_align(a), plen);
                end
            end else begin
                do_write(a, ml, 1'b0, pat, plen, as, bs, rc, wc, pc, ok, lo);
                n_tests++; if (bs !== ml || as !== model_align(a) || pc !== 1 || !ok || wc !== plen || rc !== 0 || lo !== exp_line_o) begin
                    n_fail++; $display("FAIL rand_write%0d: got beats=%h addr=%h resp=%0d ok=%b wr=%0d rd=%0d, want beats=%h addr=%h 1 1 %0d 0",
                                       it, bs, as, pc, ok, wc, rc, ml, model_align(a), plen);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; line_i = '0; address_i = 32'h0; read_i = 1'b0; write_i = 1'b0;
        burst_i = 64'h0; resp_i = 1'b0; exp_line_o = '0;
        test_reset();
        test_idle_resp();
        test_read_basic();
        test_write_basic();
        test_read_gaps();
        test_reset_mid();
        test_both();
        test_back_to_back();
        test_idle_resp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Memory-side responder for the cache's line interface.
- Accepts whole-line read (fill) and write (writeback) requests from the cache datapath/controller.
- Serializes each request into fixed-length bursts on the narrow physical-memory bus, then returns a single-cycle line response to the cache.
- Sits between the cache and main memory; one transaction in flight at a time.

Parameters:
- s_line, 256, cache line width in bits.
- s_burst, 64, memory data-bus width in bits.
- num_beats, s_line/s_burst (4), beats per line transaction.
- s_offset, 5, log2 of line size in bytes; low address bits zeroed on the memory side.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- line_i  input  s_line  writeback data from cache.
- line_o  output  s_line  assembled fill line to cache.
- address_i  input  32  line address from cache.
- read_i  input  1  cache line-read request; held until resp_o.
- write_i  input  1  cache line-write request; held until resp_o.
- resp_o  output  1  one-cycle completion pulse to cache.
- burst_i  input  s_burst  memory read beat.
- burst_o  output  s_burst  memory write beat.
- address_o  output  32  memory address, line-aligned.
- read_o  output  1  memory read request.
- write_o  output  1  memory write request.
- resp_i  input  1  memory beat strobe; one beat per cycle it is high.

Behaviour:
- Reset: state IDLE, beat count 0; line_o, burst_o, address_o = 0; read_o, write_o, resp_o = 0. Reset is honoured immediately, including mid-burst; any partial transaction is abandoned and memory must tolerate the dropped burst.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - write_i=1: latch address_i and line_i; go to WRITE.
  - Else read_i=1: latch address_i; go to READ.
  - Write has priority. Both high is illegal; only the write is serviced, and a single resp_o is returned.
- address_o = {latched address[31:s_offset], s_offset'b0}, held for the whole transaction.
- READ:
  - read_o=1.
  - Each cycle with resp_i=1: burst_i is stored into line bits [s_burst*count +: s_burst], and count increments.
  - resp_i may drop for any number of cycles between beats; count holds while resp_i=0.
  - On the beat with count=num_beats-1: count returns to 0, read_o deasserts on the next cycle, and the state goes to DONE.
- WRITE:
  - write_o=1; burst_o = latched line [s_burst*count +: s_burst], combinational from count.
  - Count advances on each resp_i=1 cycle, with the same gap and terminal rules as READ.
- DONE:
  - resp_o=1 for exactly one cycle, then return to IDLE.
  - For reads, line_o is valid in the DONE cycle and holds until the next read overwrites beat 0.
  - The DONE cycle never accepts a new request.
  - The requester deasserts its request by the cycle after resp_o; a request still high in IDLE starts a new transaction.
- read_o and write_o are never high together. Neither is high in IDLE or DONE.
- resp_i outside READ/WRITE is ignored.
- Latency: request accepted at edge 0, memory command visible from cycle 1. With resp_i continuously high, resp_o asserts one cycle after the 4th beat.
- Count width is $clog2(num_beats); wrap to 0 is explicit, not by overflow.

Decomposition:
- Shared package cache_types gains:
  - adaptor_state_t enum {IDLE, READ, WRITE, DONE};
  - localparam constants for num_beats and the count width.
- One natural sub-module, burst_shift_reg: an s_line register loadable whole (writeback latch) or per-beat (fill), with beat-select output.
- Keep it if the control FSM exceeds about 150 lines; otherwise the logic stays inline.

Test Plan:
- Read at address_i=0x0000_1047, memory returns beats 0x1111…, 0x2222…, 0x3333…, 0x4444… on 4 consecutive cycles -> address_o=0x0000_1040, read_o high 4 cycles, resp_o one cycle later, line_o = {0x4444…, 0x3333…, 0x2222…, 0x1111…}.
- Write of line_i = {D3,D2,D1,D0} at 0x0000_2000 with resp_i high 4 cycles -> write_o high, burst_o = D0,D1,D2,D3 in order, single resp_o pulse, read_o stays 0.
- Read with resp_i pattern 1,0,0,1,1,0,1 -> beats stored only on high cycles, resp_o exactly once after the 4th high, line_o correct.
- Assert rst after 2 write beats -> outputs zero asynchronously. A following read completes cleanly with count restarting at 0.
- read_i and write_i both high -> only the write burst is issued, one resp_o.
- Back-to-back read then write with requests dropped after resp_o -> no extra transaction. line_o retains the read data through the write.
